// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter for one single-port unified memory
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic             owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_d;

    // Data wins contention unless fetch has already been passed over STARVE_MAX times.
    assign grant_d = d_req && !(if_req && (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        state   <= S_ACC;
                        mem_req <= 1'b1;
                        owner_d <= grant_d;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (!if_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_LIM)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                S_ACC: begin
                    if (mem_ack) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!mem_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    // Requests are deliberately not sampled here so a requester can drop req after ready.
                    state    <= S_IDLE;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ifq;
        logic [31:0] ia;
        logic        dq, dwe;
        logic [31:0] da, dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_mreq, chk_bus, e_mwe;
        logic [31:0] e_maddr, e_mwd;
        logic        e_ir;
        logic [31:0] e_ird;
        logic        e_dr;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ifq, logic [31:0] ia, logic dq, logic dwe,
                                logic [31:0] da, logic [31:0] dwd, logic ack, logic [31:0] mrd,
                                logic emreq, logic chkbus, logic emwe, logic [31:0] emaddr,
                                logic [31:0] emwd, logic eir, logic [31:0] eird, logic edr,
                                logic [31:0] edrd);
        vec_t v;
        v.rst = r; v.ifq = ifq; v.ia = ia; v.dq = dq; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.ack = ack; v.mrd = mrd; v.e_mreq = emreq; v.chk_bus = chkbus; v.e_mwe = emwe;
        v.e_maddr = emaddr; v.e_mwd = emwd; v.e_ir = eir; v.e_ird = eird; v.e_dr = edr;
        v.e_drd = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic ifq, input logic [31:0] ia, input logic dq,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input logic ack, input logic [31:0] mrd);
        rst = r; if_req = ifq; if_addr = ia; d_req = dq; d_we = dwe; d_addr = da;
        d_wdata = dwd; mem_ack = ack; mem_rdata = mrd;
    endtask

    // Transaction-level reference: one access record, an edge counter and a grant-permit edge.
    logic        m_act, m_own_d, m_we;
    logic [31:0] m_addr, m_wd;
    logic        m_ir, m_dr;
    logic [31:0] m_ird, m_drd;
    int          m_starve, m_edge, m_grant_ok;

    task automatic model_edge(input logic r, input logic ifq, input logic [31:0] ia,
                              input logic dq, input logic dwe, input logic [31:0] da,
                              input logic [31:0] dwd, input logic ack, input logic [31:0] mrd);
        if (r) begin
            m_act = 0; m_ir = 0; m_dr = 0; m_ird = 0; m_drd = 0;
            m_starve = 0; m_grant_ok = m_edge + 1;
        end else begin
            m_ir = 0; m_dr = 0;
            if (m_act && ack) begin
                m_act = 0;
                m_grant_ok = m_edge + 2;
                if (m_own_d) begin
                    m_dr = 1;
                    if (!m_we) m_drd = mrd;
                end else begin
                    m_ir = 1;
                    m_ird = mrd;
                end
            end else if (!m_act && m_edge >= m_grant_ok && (ifq || dq)) begin
                m_act = 1;
                if (ifq && (!dq || m_starve == SMAX)) begin
                    m_own_d = 0; m_addr = ia; m_we = 0; m_wd = 0; m_starve = 0;
                end else begin
                    m_own_d = 1; m_addr = da; m_we = dwe; m_wd = dwd;
                    m_starve = ifq ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
                end
            end
        end
        m_edge++;
    endtask

    int          ng;
    logic [31:0] got[10];
    logic [31:0] exp_seq[10];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,                           0,1,0,0,0,                  0,0,0,0));
        vecs.push_back(mk(0,1,32'h100,0,0,0,0,0,0,                     1,1,0,32'h100,0,            0,0,0,0));
        vecs.push_back(mk(0,1,32'h100,0,0,0,0,1,32'h13,                0,0,0,0,0,                  1,32'h13,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                           0,0,0,0,0,                  0,32'h13,0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,0,0,1,1,32'h2000,32'hDEADBEEF,0,0,     1,1,1,32'h2000,32'hDEADBEEF, 0,32'h13,0,0));
        vecs.push_back(mk(0,0,0,1,1,32'h2000,32'hDEADBEEF,1,32'hFFFFFFFF, 0,0,0,0,0,               0,32'h13,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                           0,0,0,0,0,                  0,32'h13,0,0));
        vecs.push_back(mk(0,1,32'h200,1,0,32'h40,32'h1111,0,0,         1,1,0,32'h40,32'h1111,      0,32'h13,0,0));
        vecs.push_back(mk(0,1,32'h200,1,0,32'h40,32'h1111,1,32'hAAAA0040, 0,0,0,0,0,              0,32'h13,1,32'hAAAA0040));
        vecs.push_back(mk(0,1,32'h200,0,0,0,0,0,0,                     0,0,0,0,0,                  0,32'h13,0,32'hAAAA0040));
        vecs.push_back(mk(0,1,32'h200,0,0,0,0,0,0,                     1,1,0,32'h200,0,            0,32'h13,0,32'hAAAA0040));
        vecs.push_back(mk(0,1,32'h200,0,0,0,0,1,32'h0BAD0200,          0,0,0,0,0,                  1,32'h0BAD0200,0,32'hAAAA0040));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h12345678,                0,0,0,0,0,                  0,32'h0BAD0200,0,32'hAAAA0040));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h12345678,                0,0,0,0,0,                  0,32'h0BAD0200,0,32'hAAAA0040));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ifq, vecs[i].ia, vecs[i].dq, vecs[i].dwe,
                  vecs[i].da, vecs[i].dwd, vecs[i].ack, vecs[i].mrd);
            tick();
            chk($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_mreq});
            chk($sformatf("vec%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].e_ir});
            chk($sformatf("vec%0d d_ready", i), {31'b0, d_ready}, {31'b0, vecs[i].e_dr});
            chk($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].e_ird);
            chk($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].e_drd);
            if (vecs[i].chk_bus) begin
                chk($sformatf("vec%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mwe});
                chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            end
        end

        // Starvation: both held, zero-wait memory; D, D, D, D, IF repeating.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 32'h300, 1, 0, 32'h400, 0, 1, 32'h1);
        ng = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (mem_req === 1'b1 && ng < 10) begin
                got[ng] = mem_addr;
                ng++;
            end
        end
        for (int k = 0; k < 10; k++) exp_seq[k] = (k % 5 == 4) ? 32'h300 : 32'h400;
        chk("starve grant count", ng, 10);
        for (int k = 0; k < ng; k++) chk($sformatf("starve grant%0d addr", k), got[k], exp_seq[k]);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // Reset while in ACC abandons the access.
        drive(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst-acc mem_req before", {31'b0, mem_req}, 32'd1);
        drive(1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst-acc mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst-acc readies", {30'b0, if_ready, d_ready}, 32'd0);
        chk("rst-acc if_rdata", if_rdata, 32'd0);
        chk("rst-acc d_rdata", d_rdata, 32'd0);
        chk("rst-acc mem_addr", mem_addr, 32'd0);
        drive(0, 1, 32'h504, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post-rst mem_req", {31'b0, mem_req}, 32'd1);
        chk("post-rst mem_addr", mem_addr, 32'h504);
        drive(0, 1, 32'h504, 0, 0, 0, 0, 1, 32'h77);
        tick();
        chk("post-rst if_ready", {31'b0, if_ready}, 32'd1);
        chk("post-rst if_rdata", if_rdata, 32'h77);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // D drops req mid-access; access still completes, no second grant.
        drive(0, 0, 0, 1, 0, 32'h80, 0, 0, 0);
        tick();
        chk("drop mem_req", {31'b0, mem_req}, 32'd1);
        drive(0, 0, 0, 0, 0, 32'h84, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h84, 0, 1, 32'h55);
        tick();
        chk("drop d_ready", {31'b0, d_ready}, 32'd1);
        chk("drop d_rdata", d_rdata, 32'h55);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ng = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_req !== 1'b0 || d_ready !== 1'b0) ng++;
        end
        chk("drop no regrant", ng, 0);

        // Randomized traffic against the transaction-level reference.
        m_edge = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        model_edge(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        r, ifq, dq, dwe, ack;
            logic [31:0] ia, da, dwd, mrd;
            r   = ($urandom_range(0, 149) == 0);
            ifq = if_req;
            if (ifq && m_ir) ifq = 0;
            else if (!ifq) ifq = ($urandom_range(0, 2) == 0);
            dq = d_req;
            if (dq && (m_dr || $urandom_range(0, 15) == 0)) dq = 0;
            else if (!dq) dq = ($urandom_range(0, 2) == 0);
            dwe = $urandom_range(0, 1);
            ia  = $urandom; da = $urandom; dwd = $urandom; mrd = $urandom;
            ack = $urandom_range(0, 1);
            drive(r, ifq, ia, dq, dwe, da, dwd, ack, mrd);
            tick();
            model_edge(r, ifq, ia, dq, dwe, da, dwd, ack, mrd);
            chk("rnd mem_req", {31'b0, mem_req}, {31'b0, m_act});
            chk("rnd readies", {30'b0, if_ready, d_ready}, {30'b0, m_ir, m_dr});
            chk("rnd if_rdata", if_rdata, m_ird);
            chk("rnd d_rdata", d_rdata, m_drd);
            if (m_act) begin
                chk("rnd mem_addr", mem_addr, m_addr);
                chk("rnd mem_we", {31'b0, mem_we}, {31'b0, m_we});
                chk("rnd mem_wdata", mem_wdata, m_wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
